// File: rtl/wta_inhibit_arbiter.sv
// Winner-take-all lateral inhibition: picks one spiking neuron per event with rotating priority,
// then holds off all other neurons through DIFF_SPIKE for a fixed window.

module wta_inhibit_slice #(
  parameter int N_NEURON = 6,
  parameter int IDX_W    = 3,
  parameter int J        = 0
) (
  input  logic [IDX_W-1:0]    win,
  output logic [N_NEURON-2:0] bus
);
  // Bus of neuron J lists the other neurons in ascending order, skipping J itself
  always_comb begin
    bus = '0;
    for (int k = 0; k < N_NEURON-1; k++)
      if (int'(win) == ((k < J) ? k : k + 1)) bus[k] = 1'b1;
  end
endmodule

module wta_inhibit_arbiter #(
  parameter  int N_NEURON       = 6,
  parameter  int INHIBIT_CYCLES = 4,
  parameter  int CNT_W          = 16,
  localparam int IDX_W          = $clog2(N_NEURON),
  localparam int DW             = N_NEURON*(N_NEURON-1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N_NEURON-1:0] SPIKE_IN,
  output logic [DW-1:0]       DIFF_SPIKE,
  output logic                WIN_VALID,
  input  logic                WIN_READY,
  output logic [IDX_W-1:0]    WIN_IDX,
  output logic                BUSY,
  output logic [CNT_W-1:0]    EVT_CNT,
  output logic [CNT_W-1:0]    DROP_CNT
);
  localparam int IC_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  typedef enum logic {IDLE, INHIBIT} state_t;

  state_t            state_q, state_d;
  logic [IC_W-1:0]   cnt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  idx;
  logic              hit;
  logic              sel;
  logic              leave;
  int                t;
  logic [DW-1:0]     diff_d;

  // Round-robin search: first set bit at or above ptr, wrapping at N_NEURON-1
  always_comb begin
    win = '0;
    hit = 1'b0;
    t   = 0;
    idx = '0;
    for (int i = 0; i < N_NEURON; i++) begin
      t = int'(ptr) + i;
      if (t >= N_NEURON) t = t - N_NEURON;
      idx = IDX_W'(t);
      if (!hit && SPIKE_IN[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  for (genvar j = 0; j < N_NEURON; j++) begin : g_slice
    wta_inhibit_slice #(.N_NEURON(N_NEURON), .IDX_W(IDX_W), .J(j)) u_slice (
      .win (win),
      .bus (diff_d[j*(N_NEURON-1) +: N_NEURON-1])
    );
  end

  always_comb begin
    state_d = state_q;
    sel     = 1'b0;
    leave   = 1'b0;
    case (state_q)
      IDLE: if (|SPIKE_IN) begin
        sel     = 1'b1;
        state_d = INHIBIT;
      end
      INHIBIT: if (cnt == '0) begin
        leave   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DIFF_SPIKE <= '0;
      WIN_VALID  <= 1'b0;
      WIN_IDX    <= '0;
      BUSY       <= 1'b0;
      EVT_CNT    <= '0;
      DROP_CNT   <= '0;
      cnt        <= '0;
      ptr        <= '0;
    end else begin
      if (sel) begin
        DIFF_SPIKE <= diff_d;
        BUSY       <= 1'b1;
        cnt        <= IC_W'(INHIBIT_CYCLES-1);
        ptr        <= (int'(win) == N_NEURON-1) ? '0 : win + 1'b1;
        if (~&EVT_CNT) EVT_CNT <= EVT_CNT + 1'b1;
      end else if (leave) begin
        DIFF_SPIKE <= '0;
        BUSY       <= 1'b0;
      end else if (state_q == INHIBIT) begin
        cnt <= cnt - 1'b1;
      end

      // 1-deep output register: a new winner only lands if the slot is free or draining now
      if (sel) begin
        if (!WIN_VALID || WIN_READY) begin
          WIN_IDX   <= win;
          WIN_VALID <= 1'b1;
        end else if (~&DROP_CNT) begin
          DROP_CNT <= DROP_CNT + 1'b1;
        end
      end else if (WIN_VALID && WIN_READY) begin
        WIN_VALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wta_inhibit_arbiter.sv
// Directed bench for wta_inhibit_arbiter: selection, inhibition window, round-robin,
// backpressure drops, simultaneous accept, ignored spikes in window, mid-window reset.

module tb_wta_inhibit_arbiter;
  logic        CLK = 1'b0;
  logic        RST;
  logic [5:0]  SPIKE_IN;
  logic [29:0] DIFF_SPIKE;
  logic        WIN_VALID;
  logic        WIN_READY;
  logic [2:0]  WIN_IDX;
  logic        BUSY;
  logic [15:0] EVT_CNT;
  logic [15:0] DROP_CNT;

  int total = 0;
  int bad   = 0;

  // Expected DIFF_SPIKE images, slices packed {n5,n4,n3,n2,n1,n0}
  localparam logic [29:0] D_W1 = {5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00000, 5'b00001};
  localparam logic [29:0] D_W2 = {5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00010, 5'b00010};
  localparam logic [29:0] D_W3 = {5'b01000, 5'b01000, 5'b00000, 5'b00100, 5'b00100, 5'b00100};

  wta_inhibit_arbiter #(.N_NEURON(6), .INHIBIT_CYCLES(4), .CNT_W(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SPIKE_IN   (SPIKE_IN),
    .DIFF_SPIKE (DIFF_SPIKE),
    .WIN_VALID  (WIN_VALID),
    .WIN_READY  (WIN_READY),
    .WIN_IDX    (WIN_IDX),
    .BUSY       (BUSY),
    .EVT_CNT    (EVT_CNT),
    .DROP_CNT   (DROP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  initial begin
    logic [2:0] rr [4];
    rr[0] = 3'd0; rr[1] = 3'd5; rr[2] = 3'd0; rr[3] = 3'd5;
    SPIKE_IN  = '0;
    WIN_READY = 1'b0;
    RST       = 1'b1;
    step(2);
    RST = 1'b0;
    chk("rst_valid", WIN_VALID, 0);
    chk("rst_busy",  BUSY, 0);
    chk("rst_diff",  DIFF_SPIKE, 0);
    chk("rst_idx",   WIN_IDX, 0);
    chk("rst_evt",   EVT_CNT, 0);
    chk("rst_drop",  DROP_CNT, 0);

    // 1: single spike on neuron 2, window lasts exactly 4 cycles
    SPIKE_IN = 6'b000100;
    step();
    SPIKE_IN = '0;
    chk("t1_valid", WIN_VALID, 1);
    chk("t1_idx",   WIN_IDX, 2);
    chk("t1_busy",  BUSY, 1);
    chk("t1_diff",  DIFF_SPIKE, D_W2);
    chk("t1_evt",   EVT_CNT, 1);
    step(3);
    chk("t1_busy_c4", BUSY, 1);
    chk("t1_diff_c4", DIFF_SPIKE, D_W2);
    step();
    chk("t1_busy_end", BUSY, 0);
    chk("t1_diff_end", DIFF_SPIKE, 0);
    WIN_READY = 1'b1;
    step();
    chk("t1_drain_valid", WIN_VALID, 0);
    chk("t1_drain_idx",   WIN_IDX, 2);

    // 2: round-robin between neurons 0 and 5, one winner every 5 cycles
    do_reset();
    SPIKE_IN = 6'b100001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_valid", WIN_VALID, 1);
      chk("t2_idx",   WIN_IDX, rr[i]);
      chk("t2_busy",  BUSY, 1);
      if (i == 3) SPIKE_IN = '0;
      step(4);
      chk("t2_gap_busy", BUSY, 0);
    end
    chk("t2_evt", EVT_CNT, 4);

    // 3: backpressure, second winner dropped but still inhibits
    do_reset();
    WIN_READY = 1'b0;
    SPIKE_IN  = 6'b000010;
    step();
    SPIKE_IN = '0;
    chk("t3_idx1",  WIN_IDX, 1);
    chk("t3_diff1", DIFF_SPIKE, D_W1);
    step(4);
    SPIKE_IN = 6'b001000;
    step();
    SPIKE_IN = '0;
    chk("t3_valid", WIN_VALID, 1);
    chk("t3_idx",   WIN_IDX, 1);
    chk("t3_busy",  BUSY, 1);
    chk("t3_diff3", DIFF_SPIKE, D_W3);
    chk("t3_drop",  DROP_CNT, 1);
    chk("t3_evt",   EVT_CNT, 2);
    step(4);

    // 4: accept of idx 4 coincides with a new winner on neuron 0
    WIN_READY = 1'b1;
    step();
    chk("t4_drain", WIN_VALID, 0);
    WIN_READY = 1'b0;
    SPIKE_IN  = 6'b010000;
    step();
    SPIKE_IN = '0;
    chk("t4_idx4", WIN_IDX, 4);
    step(4);
    WIN_READY = 1'b1;
    SPIKE_IN  = 6'b000001;
    step();
    SPIKE_IN = '0;
    chk("t4_valid", WIN_VALID, 1);
    chk("t4_idx",   WIN_IDX, 0);
    chk("t4_drop",  DROP_CNT, 1);
    chk("t4_evt",   EVT_CNT, 4);
    step(4);

    // 5: spikes inside the window ignored, taken in first IDLE cycle
    SPIKE_IN = 6'b000010;
    step();
    chk("t5_idx1", WIN_IDX, 1);
    SPIKE_IN = 6'b101000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold_diff", DIFF_SPIKE, D_W1);
      chk("t5_hold_evt",  EVT_CNT, 5);
    end
    step();
    chk("t5_idle_busy", BUSY, 0);
    chk("t5_idle_diff", DIFF_SPIKE, 0);
    step();
    SPIKE_IN = '0;
    chk("t5_new_valid", WIN_VALID, 1);
    chk("t5_new_idx",   WIN_IDX, 3);
    chk("t5_new_diff",  DIFF_SPIKE, D_W3);
    chk("t5_new_evt",   EVT_CNT, 6);

    // 6: reset in window cycle 2
    step();
    chk("t6_busy_pre", BUSY, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("t6_busy",  BUSY, 0);
    chk("t6_diff",  DIFF_SPIKE, 0);
    chk("t6_valid", WIN_VALID, 0);
    chk("t6_idx",   WIN_IDX, 0);
    chk("t6_evt",   EVT_CNT, 0);
    chk("t6_drop",  DROP_CNT, 0);
    SPIKE_IN = 6'b100001;
    step();
    SPIKE_IN = '0;
    chk("t6_ptr0", WIN_IDX, 0);
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
